// File: rtl/mio_rst_gen_pkg.sv
// Shared types and default configuration for the mio_rst_gen reset-sequence generator.
package mio_rst_gen_pkg;

    localparam int unsigned DEF_CNT_W          = 16;
    localparam int unsigned DEF_POR_CYCLES     = 8;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 4;
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned PULSE_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_POR     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_DELAY   = 3'd2,
        ST_ASSERT  = 3'd3,
        ST_HOLDOFF = 3'd4
    } mio_rst_gen_state_t;

endpackage

// File: rtl/mio_rst_gen_sync.sv
// Async-assert / sync-release reset synchronizer producing the generator's internal reset.
module mio_rst_gen_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mio_rst_gen.sv
// Reset-sequence generator: power-on reset, then programmable delayed reset pulses on request.
// Optional completed-pulse counter enabled by defining MIO_RST_GEN_PULSE_CNT_EN.
module mio_rst_gen
    import mio_rst_gen_pkg::*;
#(
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned POR_CYCLES     = DEF_POR_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rst_o,
    output logic             rst_n_o
`ifdef MIO_RST_GEN_PULSE_CNT_EN
    ,
    output logic [PULSE_CNT_W-1:0] pulse_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mio_rst_gen_state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic               rst_q, rst_d;
    logic               rst_n_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rst_int;
    logic               cnt_zero;
    logic               assert_exit;

    mio_rst_gen_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .rst_sync_o(rst_int)
    );

    // Pulse width of 0 behaves as 1; counter holds remaining cycles minus one.
    function automatic logic [CNT_W-1:0] width_load(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : (w - CNT_ONE);
    endfunction

    assign cnt_zero    = (cnt_q == '0);
    assign assert_exit = (state_q == ST_ASSERT) && !rst_int && cnt_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        if (rst_int) begin
            state_d = ST_POR;
            cnt_d   = POR_LOAD;
        end else begin
            case (state_q)
                ST_POR: begin
                    if (cnt_zero) state_d = ST_IDLE;
                    else          cnt_d   = cnt_q - CNT_ONE;
                end
                ST_IDLE: begin
                    if (req_i) begin
                        width_d = width_i;
                        if (delay_i == '0) begin
                            state_d = ST_ASSERT;
                            cnt_d   = width_load(width_i);
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_i - CNT_ONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_zero) begin
                        state_d = ST_ASSERT;
                        cnt_d   = width_load(width_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_zero) begin
                        if (HOLDOFF_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLD_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_zero) state_d = ST_IDLE;
                    else          cnt_d   = cnt_q - CNT_ONE;
                end
                default: state_d = ST_POR;
            endcase
        end
    end

    // Outputs are decoded from the next state so every output is a plain flop.
    always_comb begin
        rst_d  = (state_d == ST_POR) || (state_d == ST_ASSERT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            width_q <= '0;
            rst_q   <= 1'b1;
            rst_n_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            rst_q   <= rst_d;
            rst_n_q <= ~rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rst_o   = rst_q;
    assign rst_n_o = rst_n_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

`ifdef MIO_RST_GEN_PULSE_CNT_EN
    logic [PULSE_CNT_W-1:0] pulse_cnt_q;

    // Saturating count of completed requested pulses; POR never counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt_q <= '0;
        end else if (assert_exit && (pulse_cnt_q != '1)) begin
            pulse_cnt_q <= pulse_cnt_q + PULSE_CNT_W'(1);
        end
    end

    assign pulse_cnt_o = pulse_cnt_q;
`else
    logic unused_assert_exit;
    assign unused_assert_exit = assert_exit;
`endif

endmodule

// File: tb/tb_mio_rst_gen.sv
// Directed self-checking bench for mio_rst_gen (default parameters).
// Pulse-counter checks are compiled in when MIO_RST_GEN_PULSE_CNT_EN is defined.
module tb_mio_rst_gen;

    localparam int SYNC    = 2;
    localparam int PORC    = 8;
    localparam int HOLD    = 4;
    localparam int POR_TOT = SYNC + PORC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic [15:0] delay_i = '0;
    logic [15:0] width_i = '0;
    logic        busy_o, done_o, rst_o, rst_n_o;
`ifdef MIO_RST_GEN_PULSE_CNT_EN
    logic [15:0] pulse_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mio_rst_gen dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .delay_i    (delay_i),
        .width_i    (width_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rst_o      (rst_o),
        .rst_n_o    (rst_n_o)
`ifdef MIO_RST_GEN_PULSE_CNT_EN
        ,
        .pulse_cnt_o(pulse_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release reset and follow the full power-on sequence into IDLE.
    task automatic por_release();
        reset = 1'b0;
        for (int k = 1; k <= POR_TOT + 1; k++) begin
            tick();
            check("por_rst",   32'(rst_o),   32'(k < POR_TOT));
            check("por_rst_n", 32'(rst_n_o), 32'(k >= POR_TOT));
            check("por_busy",  32'(busy_o),  32'(k < POR_TOT));
            check("por_done",  32'(done_o),  32'(k == POR_TOT));
        end
    endtask

    // One requested pulse from IDLE; k counts edges after the accept edge (k=0).
    task automatic run_pulse(input int d, input int w, input bit interfere);
        int wq;
        int tend;
        wq   = (w == 0) ? 1 : w;
        tend = d + wq + HOLD;
        req_i   = 1'b1;
        delay_i = 16'(d);
        width_i = 16'(w);
        tick();
        req_i = 1'b0;
        for (int k = 0; k <= tend + 1; k++) begin
            if (k > 0) tick();
            check("pls_rst",   32'(rst_o),   32'(k >= d && k < d + wq));
            check("pls_rst_n", 32'(rst_n_o), 32'(!(k >= d && k < d + wq)));
            check("pls_busy",  32'(busy_o),  32'(k < tend));
            check("pls_done",  32'(done_o),  32'(k == tend));
            if (interfere && (k == 1 || k == 2)) begin
                req_i   = 1'b1;
                delay_i = 16'd1;
                width_i = 16'd9;
            end else begin
                req_i   = 1'b0;
                delay_i = 16'(d);
                width_i = 16'(w);
            end
        end
    endtask

    initial begin
        // Reset state while reset is held.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_rst",   32'(rst_o),   32'd1);
            check("rst_rst_n", 32'(rst_n_o), 32'd0);
            check("rst_busy",  32'(busy_o),  32'd1);
            check("rst_done",  32'(done_o),  32'd0);
        end
`ifdef MIO_RST_GEN_PULSE_CNT_EN
        check("cnt_reset", 32'(pulse_cnt_o), 32'd0);
`endif
        por_release();
`ifdef MIO_RST_GEN_PULSE_CNT_EN
        check("cnt_por", 32'(pulse_cnt_o), 32'd0);
`endif

        run_pulse(3, 5, 1'b0);
        run_pulse(0, 0, 1'b0);
        run_pulse(6, 3, 1'b1);
        run_pulse(1, 2, 1'b0);

        // Abort during DELAY: rst_o must rise before the next clock edge.
        req_i   = 1'b1;
        delay_i = 16'd50;
        width_i = 16'd2;
        tick();
        req_i = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("dly_rst_pre", 32'(rst_o), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_dly_rst",   32'(rst_o),   32'd1);
        check("abort_dly_rst_n", 32'(rst_n_o), 32'd0);
        check("abort_dly_busy",  32'(busy_o),  32'd1);
        tick();
        por_release();

        // Abort during a long ASSERT phase.
        req_i   = 1'b1;
        delay_i = 16'd0;
        width_i = 16'd100;
        tick();
        req_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("asrt_rst", 32'(rst_o), 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("abort_asrt_rst",  32'(rst_o),  32'd1);
        check("abort_asrt_done", 32'(done_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("abort_hold_done", 32'(done_o), 32'd0);
            check("abort_hold_busy", 32'(busy_o), 32'd1);
        end
        por_release();

`ifdef MIO_RST_GEN_PULSE_CNT_EN
        check("cnt_after_abort", 32'(pulse_cnt_o), 32'd0);
        run_pulse(0, 1, 1'b0);
        run_pulse(2, 1, 1'b0);
        run_pulse(0, 3, 1'b0);
        check("cnt_three", 32'(pulse_cnt_o), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
